// File: rtl/rsa16_ahb_pkg.sv
// Shared constants for the rsa16 AHB-Lite controller: register map,
// CTRL/STATUS bit positions, controller state encoding and HTRANS codes.
package rsa16_ahb_pkg;

    // Register byte offsets
    localparam logic [7:0] OFS_BASE   = 8'h00;
    localparam logic [7:0] OFS_EXP    = 8'h04;
    localparam logic [7:0] OFS_N      = 8'h08;
    localparam logic [7:0] OFS_CTRL   = 8'h0C;
    localparam logic [7:0] OFS_STATUS = 8'h10;
    localparam logic [7:0] OFS_RESULT = 8'h14;

    // CTRL bits
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // STATUS bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // AHB HTRANS codes; bit 1 set marks a real transfer
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/rsa16_ahb_if.sv
// AHB-Lite slave-side bus bundle for the rsa16 controller.
interface rsa16_ahb_if #(
    parameter int ADDR_W = 8
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [31:0]       hwdata;
    logic              hready;
    logic [31:0]       hrdata;
    logic              hreadyout;
    logic              hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/rsa16_ahb_regs.sv
// AHB-Lite register front end: address-phase capture, write decode for the
// operand/control registers, W1C/start strobes and the read-data mux.
module rsa16_ahb_regs
    import rsa16_ahb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    rsa16_ahb_if.slave  ahb,
    input  logic        i_busy,
    input  logic        i_done,
    input  logic        i_err,
    input  logic [15:0] i_result,
    output logic [15:0] o_base,
    output logic [15:0] o_exp,
    output logic [15:0] o_n,
    output logic        o_irq_en,
    output logic        o_start_req,
    output logic        o_done_clr,
    output logic        o_err_clr
);

    logic              dph_valid_q, dph_valid_d;
    logic              dph_write_q, dph_write_d;
    logic [ADDR_W-1:0] dph_addr_q,  dph_addr_d;
    logic [15:0]       base_q, base_d;
    logic [15:0]       exp_q,  exp_d;
    logic [15:0]       n_q,    n_d;
    logic              irq_en_q, irq_en_d;

    logic wr_en, rd_en;
    logic hit_base, hit_exp, hit_n, hit_ctrl, hit_status, hit_result;
    logic unused_bits;

    assign ahb.hreadyout = 1'b1;
    assign ahb.hresp     = 1'b0;
    assign unused_bits   = ^{ahb.hwdata[31:16], ahb.htrans[0]};

    assign wr_en = dph_valid_q &  dph_write_q;
    assign rd_en = dph_valid_q & ~dph_write_q;

    assign hit_base   = (dph_addr_q == ADDR_W'(OFS_BASE));
    assign hit_exp    = (dph_addr_q == ADDR_W'(OFS_EXP));
    assign hit_n      = (dph_addr_q == ADDR_W'(OFS_N));
    assign hit_ctrl   = (dph_addr_q == ADDR_W'(OFS_CTRL));
    assign hit_status = (dph_addr_q == ADDR_W'(OFS_STATUS));
    assign hit_result = (dph_addr_q == ADDR_W'(OFS_RESULT));

    // Capture the address phase only when the bus advances
    always_comb begin
        dph_valid_d = dph_valid_q;
        dph_write_d = dph_write_q;
        dph_addr_d  = dph_addr_q;
        if (ahb.hready) begin
            dph_valid_d = ahb.hsel & ahb.htrans[1];
            dph_write_d = ahb.hwrite;
            dph_addr_d  = ahb.haddr;
        end
    end

    // Register writes; operands are frozen while the core is running
    always_comb begin
        base_d   = base_q;
        exp_d    = exp_q;
        n_d      = n_q;
        irq_en_d = irq_en_q;
        if (wr_en) begin
            if (!i_busy) begin
                if (hit_base) base_d = ahb.hwdata[15:0];
                if (hit_exp)  exp_d  = ahb.hwdata[15:0];
                if (hit_n)    n_d    = ahb.hwdata[15:0];
            end
            if (hit_ctrl) irq_en_d = ahb.hwdata[CTRL_IRQ_EN];
        end
    end

    // State update for bus capture and software-visible registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            dph_addr_q  <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            n_q         <= '0;
            irq_en_q    <= 1'b0;
        end else begin
            dph_valid_q <= dph_valid_d;
            dph_write_q <= dph_write_d;
            dph_addr_q  <= dph_addr_d;
            base_q      <= base_d;
            exp_q       <= exp_d;
            n_q         <= n_d;
            irq_en_q    <= irq_en_d;
        end
    end

    assign o_start_req = wr_en & hit_ctrl   & ahb.hwdata[CTRL_START];
    assign o_done_clr  = wr_en & hit_status & ahb.hwdata[STAT_DONE];
    assign o_err_clr   = wr_en & hit_status & ahb.hwdata[STAT_ERR];
    assign o_base      = base_q;
    assign o_exp       = exp_q;
    assign o_n         = n_q;
    assign o_irq_en    = irq_en_q;

    // Read mux from the registered data-phase address
    always_comb begin
        ahb.hrdata = 32'h0;
        if (rd_en) begin
            if (hit_base)   ahb.hrdata[15:0] = base_q;
            if (hit_exp)    ahb.hrdata[15:0] = exp_q;
            if (hit_n)      ahb.hrdata[15:0] = n_q;
            if (hit_ctrl)   ahb.hrdata[CTRL_IRQ_EN] = irq_en_q;
            if (hit_status) begin
                ahb.hrdata[STAT_BUSY] = i_busy;
                ahb.hrdata[STAT_DONE] = i_done;
                ahb.hrdata[STAT_ERR]  = i_err;
            end
            if (hit_result) ahb.hrdata[15:0] = i_result;
        end
    end

endmodule

// File: rtl/rsa16_ahb_ctrl.sv
// rsa16 modular-exponentiation controller: AHB-Lite register slave plus the
// start/wait sequencer with a completion watchdog and a level interrupt.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no operation in flight; a START write launches the core
//   ST_START | o_core_start high for this one cycle, watchdog reloaded
//   ST_WAIT  | waiting for i_core_end or watchdog expiry
//
// The watchdog window is TIMEOUT cycles counted from the start-pulse cycle:
// without an end pulse, ERR/DONE become visible TIMEOUT cycles after it.
module rsa16_ahb_ctrl
    import rsa16_ahb_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    rsa16_ahb_if.slave  ahb,
    output logic        o_core_start,
    output logic [15:0] o_core_base,
    output logic [15:0] o_core_exp,
    output logic [15:0] o_core_N,
    input  logic [15:0] i_core_result,
    input  logic        i_core_end,
    output logic        o_irq
);

    localparam bit WD_ON = (TIMEOUT != 0);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    state_e          state_q, state_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     result_q, result_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    logic        busy, irq_en, start_req, done_clr, err_clr, wd_expire;
    logic [15:0] op_n;

    assign busy      = (state_q != ST_IDLE);
    assign wd_expire = WD_ON && (wdog_q <= WD_W'(1));

    rsa16_ahb_regs #(.ADDR_W(ADDR_W)) u_regs (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .ahb         (ahb),
        .i_busy      (busy),
        .i_done      (done_q),
        .i_err       (err_q),
        .i_result    (result_q),
        .o_base      (o_core_base),
        .o_exp       (o_core_exp),
        .o_n         (op_n),
        .o_irq_en    (irq_en),
        .o_start_req (start_req),
        .o_done_clr  (done_clr),
        .o_err_clr   (err_clr)
    );

    assign o_core_N = op_n;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_req && (op_n != 16'h0)) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (i_core_end || wd_expire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs, status flags, result capture and watchdog; flag sets beat W1C
    always_comb begin
        o_core_start = (state_q == ST_START);
        done_d       = done_q;
        err_d        = err_q;
        result_d     = result_q;
        wdog_d       = wdog_q;
        if (done_clr) done_d = 1'b0;
        if (err_clr)  err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (op_n == 16'h0) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b0;
                        done_d = 1'b0;
                    end
                end
            end
            ST_START: wdog_d = WD_LOAD;
            ST_WAIT: begin
                if (i_core_end) begin
                    result_d = i_core_result;
                    done_d   = 1'b1;
                end else if (wd_expire) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    wdog_d = wdog_q - WD_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Flag, result and watchdog registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            wdog_q   <= '0;
        end else begin
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            wdog_q   <= wdog_d;
        end
    end

    assign o_irq = irq_en & done_q;

endmodule

// File: tb/tb_rsa16_ahb_ctrl.sv
// Directed + randomized bench for rsa16_ahb_ctrl with a register-level
// reference model and an arithmetic modexp model standing in for the core.
module tb_rsa16_ahb_ctrl;
    import rsa16_ahb_pkg::*;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        core_start, core_end, irq;
    logic [15:0] core_base, core_exp, core_n, core_result;

    rsa16_ahb_if #(.ADDR_W(8)) bus ();

    rsa16_ahb_ctrl #(.ADDR_W(8), .TIMEOUT(TMO)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .ahb           (bus),
        .o_core_start  (core_start),
        .o_core_base   (core_base),
        .o_core_exp    (core_exp),
        .o_core_N      (core_n),
        .i_core_result (core_result),
        .i_core_end    (core_end),
        .o_irq         (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    // Reference register state
    logic [15:0] m_base, m_exp, m_n, m_result;
    bit          m_irq_en, m_done, m_err, m_busy;

    always @(posedge clk) if (core_start) n_starts++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e,
                                           input logic [15:0] n);
        longint unsigned r, x, nn;
        nn = n;
        r  = 1 % nn;
        x  = b % nn;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_base = 0; m_exp = 0; m_n = 0; m_result = 0;
        m_irq_en = 0; m_done = 0; m_err = 0; m_busy = 0;
    endtask

    task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.hwrite = 1'b1; bus.haddr = a;
        @(negedge clk);
        bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0; bus.hwdata = d;
    endtask

    task automatic ahb_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.hwrite = 1'b0; bus.haddr = a;
        @(negedge clk);
        bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
        #1 d = bus.hrdata;
    endtask

    // Bus write plus the register-map rules applied to the model
    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        ahb_wr(a, d);
        case (a)
            OFS_BASE: if (!m_busy) m_base = d[15:0];
            OFS_EXP:  if (!m_busy) m_exp  = d[15:0];
            OFS_N:    if (!m_busy) m_n    = d[15:0];
            OFS_CTRL: begin
                m_irq_en = d[1];
                if (d[0] && !m_busy) begin
                    if (m_n == 0) begin m_err = 1; m_done = 1; end
                    else begin m_err = 0; m_done = 0; m_busy = 1; end
                end
            end
            OFS_STATUS: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        ahb_rd(OFS_BASE, d);   chk({tag, " BASE"}, d, {16'h0, m_base});
        ahb_rd(OFS_EXP, d);    chk({tag, " EXP"}, d, {16'h0, m_exp});
        ahb_rd(OFS_N, d);      chk({tag, " N"}, d, {16'h0, m_n});
        ahb_rd(OFS_CTRL, d);   chk({tag, " CTRL"}, d, {30'h0, m_irq_en, 1'b0});
        ahb_rd(OFS_STATUS, d); chk({tag, " STATUS"}, d, {29'h0, m_err, m_done, m_busy});
        ahb_rd(OFS_RESULT, d); chk({tag, " RESULT"}, d, {16'h0, m_result});
        ahb_rd(8'h18, d);      chk({tag, " unmapped"}, d, 32'h0);
        chk({tag, " irq"}, irq, m_irq_en & m_done);
        chk({tag, " ports"}, {core_base, core_exp}, {m_base, m_exp});
        chk({tag, " port N"}, core_n, m_n);
    endtask

    // Writes START and checks the pulse: one cycle long, one cycle after the data phase
    task automatic run_start(input string tag, input bit irq_en);
        int s0;
        bit exp_pulse;
        s0 = n_starts;
        exp_pulse = !m_busy && (m_n != 0);
        reg_wr(OFS_CTRL, {30'h0, irq_en, 1'b1});
        @(negedge clk); chk({tag, " start pulse"}, core_start, exp_pulse);
        @(negedge clk); chk({tag, " start single"}, core_start, 1'b0);
        chk({tag, " start count"}, n_starts - s0, exp_pulse);
    endtask

    task automatic core_finish(input logic [15:0] res);
        @(negedge clk); core_end = 1'b1; core_result = res;
        @(negedge clk); core_end = 1'b0;
        if (m_busy) begin m_result = res; m_done = 1; m_busy = 0; end
    endtask

    initial begin
        logic [31:0] d;
        int s0, k;
        logic [15:0] r;

        rstn = 1'b0;
        bus.hsel = 0; bus.haddr = 0; bus.htrans = HTRANS_IDLE; bus.hwrite = 0;
        bus.hwdata = 0; bus.hready = 1'b1;
        core_end = 0; core_result = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst irq", irq, 1'b0);
        chk("rst start", core_start, 1'b0);
        chk("rst hrdata", bus.hrdata, 32'h0);
        rstn = 1'b1;
        check_regs("reset");

        // 4^13 mod 497 with interrupt enabled
        reg_wr(OFS_BASE, 4); reg_wr(OFS_EXP, 13); reg_wr(OFS_N, 497);
        run_start("t1", 1'b1);
        ahb_rd(OFS_STATUS, d); chk("t1 busy", d, 32'h1);
        core_finish(modexp(m_base, m_exp, m_n));
        ahb_rd(OFS_RESULT, d); chk("t1 result445", d, 32'd445);
        ahb_rd(OFS_STATUS, d); chk("t1 status", d, 32'h2);
        chk("t1 irq", irq, 1'b1);
        reg_wr(OFS_STATUS, 32'h2);
        @(negedge clk); chk("t1 irq clr", irq, 1'b0);
        check_regs("t1");

        // Operand and START writes ignored while busy
        reg_wr(OFS_BASE, 2); reg_wr(OFS_EXP, 10); reg_wr(OFS_N, 1000);
        run_start("t2", 1'b0);
        s0 = n_starts;
        reg_wr(OFS_BASE, 7);
        reg_wr(OFS_CTRL, 32'h1);
        ahb_rd(OFS_BASE, d); chk("t2 base held", d, 32'd2);
        core_finish(modexp(m_base, m_exp, m_n));
        chk("t2 no restart", n_starts - s0, 0);
        ahb_rd(OFS_RESULT, d); chk("t2 result24", d, 32'd24);
        check_regs("t2");

        // N == 0: immediate error, no core start
        reg_wr(OFS_N, 0);
        run_start("t3", 1'b0);
        ahb_rd(OFS_STATUS, d); chk("t3 status", d, 32'h6);
        check_regs("t3");

        // Watchdog: withhold end; flags appear TMO cycles after the pulse
        reg_wr(OFS_N, 77);
        run_start("t4", 1'b1);
        k = 1;
        while (!irq && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("t4 timeout cycle", k, TMO);
        m_err = 1; m_done = 1; m_busy = 0;
        ahb_rd(OFS_STATUS, d); chk("t4 status", d, 32'h6);
        check_regs("t4");

        // W1C of DONE in the same cycle as the end pulse: set wins
        run_start("t5", 1'b1);
        r = modexp(m_base, m_exp, m_n);
        @(negedge clk);
        bus.hsel = 1; bus.htrans = HTRANS_NONSEQ; bus.hwrite = 1; bus.haddr = OFS_STATUS;
        @(negedge clk);
        bus.hsel = 0; bus.htrans = HTRANS_IDLE; bus.hwrite = 0; bus.hwdata = 32'h2;
        core_end = 1; core_result = r;
        @(negedge clk); core_end = 0;
        m_result = r; m_done = 1; m_busy = 0;
        check_regs("t5");
        reg_wr(8'h18, 32'hFFFF_FFFF);

        // End pulse while idle is ignored
        core_finish(16'hBEEF);
        check_regs("t6");

        // Reset mid-operation, then a fresh run
        reg_wr(OFS_BASE, 4); reg_wr(OFS_EXP, 13); reg_wr(OFS_N, 497);
        run_start("t7", 1'b1);
        @(negedge clk); rstn = 1'b0;
        #1;
        chk("t7 rst start", core_start, 1'b0);
        chk("t7 rst irq", irq, 1'b0);
        chk("t7 rst base", core_base, 16'h0);
        model_reset();
        @(negedge clk); rstn = 1'b1;
        check_regs("t7 after rst");
        reg_wr(OFS_BASE, 4); reg_wr(OFS_EXP, 13); reg_wr(OFS_N, 497);
        run_start("t7b", 1'b1);
        core_finish(modexp(m_base, m_exp, m_n));
        ahb_rd(OFS_RESULT, d); chk("t7 result445", d, 32'd445);

        // Randomized operand runs against the model
        for (int it = 0; it < 8; it++) begin
            reg_wr(OFS_BASE, $urandom);
            reg_wr(OFS_EXP, $urandom);
            reg_wr(OFS_N, ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom);
            run_start($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)));
            if (m_busy) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                core_finish(modexp(m_base, m_exp, m_n));
            end
            check_regs($sformatf("rnd%0d", it));
            if ($urandom_range(0, 1) == 1) reg_wr(OFS_STATUS, 32'h6);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
